decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//   Decode stage directly downstream of fetch. Tracks the 2-cycle fetch-memory
//   latency, tags each returning word with its PC, decodes it, and issues it to
//   execute. Resolves branches at issue, driving fetch's branch_en/branch_val.
//   Back-pressures fetch through stall; a skid buffer absorbs in-flight words.
// PARAMETERS
//   AW         16  instruction address width
//   DW         16  instruction width
//   FETCH_LAT  2   cycles from fetch_addr to fetch_data (fixed; must equal SKID_DEPTH)
//   SKID_DEPTH 2   skid FIFO entries
// PORTS
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   core_en     in   1   core enable (same signal fed to fetch)
//   fetch_addr  in   AW  address fetch is presenting this cycle
//   ins         in   DW  word returned by fetch (0 = bubble)
//   stall       out  1   to fetch: hold PC
//   branch_en   out  1   to fetch: redirect (combinational, issue cycle)
//   branch_val  out  AW  redirect target
//   ex_ready    in   1   execute accepts this cycle
//   zero_flag   in   1   execute's current-cell==0, valid in the issue cycle
//   dec_valid   out  1   decoded op valid
//   dec_op      out  4   opcode
//   dec_imm     out  16  sign-extended ins[11:0]
//   dec_pc      out  AW  PC of issued op
//   illegal     out  1   1-cycle pulse: undefined opcode issued (executes as NOP)
//   halted      out  1   HALT issued; sticky until reset
//   perf_taken  out  16  taken-branch count (see CONFIGURATION)
//   perf_stall  out  16  stall-cycle count (see CONFIGURATION)
// BEHAVIOUR
//   Reset: all outputs 0; FIFO empty; in-flight valid bits cleared; state RUN.
//   ISA: op=ins[15:12]: 0 NOP, 1 ADD, 2 MOVE, 3 IN, 4 OUT, 5 JZ, 6 JNZ, 7 JMP,
//     F HALT; 8-E illegal. JZ/JNZ target = pc + sext(imm12), mod 2^AW;
//     JMP target = zext(imm12).
//   In-flight tracking: 2-deep shift of {v,addr}; new request v = core_en &
//     !stall | branch_en. Arrival valid iff v_d2 & core_en.
//   Issue: dec_* is an output register; issued when dec_valid & ex_ready. The
//     register refills same cycle from FIFO head, else from a valid arrival.
//     When the register is full and not issuing, valid arrivals push into FIFO.
//   stall = !core_en | halted | (dec_valid & !ex_ready) | fifo_count!=0.
//     Invariant (assert): FIFO never overflows; push-when-full is an error.
//   Branch: on issue of JMP, JZ with zero_flag=1, or JNZ with zero_flag=0:
//     branch_en=1 with branch_val=target; same edge clears v_d1/v_d2, flushes
//     FIFO, drops the refill. Not-taken: no redirect, no flush.
//   Branch + stall same cycle: branch wins (fetch gives stall priority, so
//     stall is forced 0 when branch_en=1).
//   HALT issue: state->HALTED; halted=1, dec_valid=0, FIFO/in-flight flushed,
//     stall=1, no further issue until rst_n.
//   core_en low: flush FIFO and in-flight bits, dec_valid=0 next edge.
//   Reset mid-operation: asynchronous; everything returns to reset values.
// CONFIGURATION
//   DECODE_PERF_EN defined: perf_taken += 1 per taken branch, perf_stall += 1
//     per cycle stall=1 while core_en=1; both saturate at 16'hFFFF.
//   Not defined: counters not built; perf_taken/perf_stall tied 0.
// STRUCTURE
//   threadbrain_pkg: opcode localparams (OP_NOP..OP_HALT), op_t typedef,
//     state enum {ST_RUN, ST_HALTED}.
//   Sub-module decode_skid_fifo: SKID_DEPTH x (AW+DW), push/pop/flush, count.
// TESTING
//   Straight line 0x1001,0x2FFF,0x4000 at PC 0..2, ex_ready=1 -> dec_imm 1,
//     FFFF, 0; dec_pc 0,1,2 on consecutive cycles, stall=0.
//   ex_ready low 3 cycles mid-stream -> stall=1, 2 words skidded, no loss or
//     duplicate; order resumes when ex_ready returns.
//   JZ 0x5FFC at PC 8, zero_flag=1 -> branch_en=1, branch_val=4; the 2 words
//     after PC 8 never issue; next dec_pc=4. zero_flag=0 -> next dec_pc=9.
//   JMP 0x7123 issued while FIFO holds 2 entries -> branch_val=0x0123, FIFO
//     flushed, stall=0 that cycle.
//   0x9000 -> illegal pulses 1 cycle; 0xF000 -> halted=1, stall stays 1.
//   rst_n low mid-skid -> all outputs 0 asynchronously; DECODE_PERF_EN build:
//     3 taken branches -> perf_taken=3.

Source files
------------

// File: rtl/threadbrain_pkg.sv
// Shared ISA and state definitions for the decode stage.
package threadbrain_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_NOP  = 4'h0;
  localparam op_t OP_ADD  = 4'h1;
  localparam op_t OP_MOVE = 4'h2;
  localparam op_t OP_IN   = 4'h3;
  localparam op_t OP_OUT  = 4'h4;
  localparam op_t OP_JZ   = 4'h5;
  localparam op_t OP_JNZ  = 4'h6;
  localparam op_t OP_JMP  = 4'h7;
  localparam op_t OP_HALT = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Opcodes 8..E are undefined and execute as NOP.
  function automatic logic op_is_illegal(input op_t op);
    case (op)
      OP_NOP, OP_ADD, OP_MOVE, OP_IN, OP_OUT,
      OP_JZ, OP_JNZ, OP_JMP, OP_HALT: return 1'b0;
      default:                        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/decode_skid_fifo.sv
// Small skid FIFO holding {pc, word} pairs that arrive while decode is full.
module decode_skid_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head_c,
  output logic [CW-1:0] count,
  output logic          empty_c
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty_c = (count == '0);
    full    = (count == CW'(DEPTH));
    head_c  = mem_q[rd_ptr];
    push_ok = push & !flush;
    pop_ok  = pop & !flush & !empty_c;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // In-flight depth equals FIFO depth, so a net push into a full FIFO is a design bug.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && !flush && full))
    else $error("decode_skid_fifo overflow");

endmodule

// File: rtl/decode.sv
// Decode stage: tracks fetch latency, skids in-flight words, decodes, issues, resolves branches.
// Optional perf counters are built when DECODE_PERF_EN is defined.
module decode
  import threadbrain_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned FETCH_LAT  = 2,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_en,
  input  logic [AW-1:0] fetch_addr,
  input  logic [DW-1:0] ins,
  output logic          stall,
  output logic          branch_en,
  output logic [AW-1:0] branch_val,
  input  logic          ex_ready,
  input  logic          zero_flag,
  output logic          dec_valid,
  output logic [3:0]    dec_op,
  output logic [15:0]   dec_imm,
  output logic [AW-1:0] dec_pc,
  output logic          illegal,
  output logic          halted,
  output logic [15:0]   perf_taken,
  output logic [15:0]   perf_stall
);

  localparam int unsigned EW = AW + DW;
  localparam int unsigned CW = $clog2(SKID_DEPTH + 1);

  state_t                       state;
  logic [FETCH_LAT-1:0]         v_pipe;
  logic [FETCH_LAT-1:0][AW-1:0] a_pipe;

  logic          run_c, arr_v_c, issue_c, taken_c, halt_issue_c, flush_c;
  logic          load_c, req_c, src_v_c;
  logic          fifo_push_c, fifo_pop_c, fifo_empty_c;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_head_c, src_c;
  logic [AW-1:0] src_pc_c;
  logic [DW-1:0] src_ins_c;

  // Issue, branch resolution, back-pressure and refill steering.
  always_comb begin
    taken_c    = 1'b0;
    branch_val = '0;
    run_c      = (state == ST_RUN);
    arr_v_c    = v_pipe[FETCH_LAT-1] & core_en;
    issue_c    = dec_valid & ex_ready;
    case (dec_op)
      OP_JMP: begin
        taken_c    = 1'b1;
        branch_val = AW'(dec_imm[11:0]);
      end
      OP_JZ: begin
        taken_c    = zero_flag;
        branch_val = dec_pc + AW'($signed(dec_imm));
      end
      OP_JNZ: begin
        taken_c    = !zero_flag;
        branch_val = dec_pc + AW'($signed(dec_imm));
      end
      default: ;
    endcase
    branch_en    = issue_c & taken_c;
    halt_issue_c = issue_c & (dec_op == OP_HALT);
    flush_c      = branch_en | halt_issue_c | !core_en;
    // Fetch honours stall over branch, so a redirect must never see stall.
    stall        = !branch_en & (!core_en | halted | (dec_valid & !ex_ready) |
                                 (fifo_count != '0));
    req_c        = branch_en | (core_en & !stall & !halt_issue_c & run_c);
    load_c       = run_c & (!dec_valid | issue_c);
    fifo_pop_c   = load_c & !fifo_empty_c & !flush_c;
    fifo_push_c  = arr_v_c & !flush_c & run_c & !(load_c & fifo_empty_c);
    src_c        = fifo_empty_c ? {a_pipe[FETCH_LAT-1], ins} : fifo_head_c;
    src_v_c      = !fifo_empty_c | arr_v_c;
    src_pc_c     = src_c[EW-1:DW];
    src_ins_c    = src_c[DW-1:0];
  end

  decode_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .W     (EW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push_c),
    .pop     (fifo_pop_c),
    .flush   (flush_c),
    .din     ({a_pipe[FETCH_LAT-1], ins}),
    .head_c  (fifo_head_c),
    .count   (fifo_count),
    .empty_c (fifo_empty_c)
  );

  // In-flight tracking, decode register and run/halt state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      v_pipe    <= '0;
      a_pipe    <= '0;
      dec_valid <= 1'b0;
      dec_op    <= '0;
      dec_imm   <= '0;
      dec_pc    <= '0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      v_pipe  <= {v_pipe[FETCH_LAT-2:0] & {(FETCH_LAT-1){!flush_c}}, req_c};
      a_pipe  <= {a_pipe[FETCH_LAT-2:0], (branch_en ? branch_val : fetch_addr)};
      illegal <= issue_c & op_is_illegal(dec_op);
      if (halt_issue_c) begin
        state  <= ST_HALTED;
        halted <= 1'b1;
      end
      if (flush_c || !run_c) begin
        dec_valid <= 1'b0;
      end else if (load_c) begin
        dec_valid <= src_v_c;
        if (src_v_c) begin
          dec_op  <= src_ins_c[15:12];
          dec_imm <= 16'($signed(src_ins_c[11:0]));
          dec_pc  <= src_pc_c;
        end
      end
    end
  end

`ifdef DECODE_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_taken <= '0;
      perf_stall <= '0;
    end else begin
      if (branch_en && perf_taken != 16'hFFFF) perf_taken <= perf_taken + 16'd1;
      if (stall && core_en && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`else
  assign perf_taken = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: a fetch/memory model feeds the DUT and an
// architectural walk of each program predicts the issued stream.
module tb_decode;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_en = 1'b0;
  logic          ex_ready = 1'b1;
  logic          zero_flag = 1'b0;
  logic [AW-1:0] fetch_addr, branch_val, dec_pc;
  logic [DW-1:0] ins;
  logic          stall, branch_en, dec_valid, illegal, halted;
  logic [3:0]    dec_op;
  logic [15:0]   dec_imm, perf_taken, perf_stall;

  logic [AW-1:0] pc_q, a1, a2;
  logic [15:0]   mem [0:1023];

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  op;
    logic [15:0] imm;
    logic        taken;
    logic [15:0] target;
  } exp_t;

  exp_t        exp_q[$];
  int          issue_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          rnd_ready = 0;
  bit          chk_stall0 = 0;
  logic [15:0] hold_pc = '0;
  int          hold_left = 0;
  logic        prev_ill = 1'b0;

  decode #(.AW(AW), .DW(DW), .FETCH_LAT(2), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .core_en(core_en), .fetch_addr(fetch_addr), .ins(ins),
    .stall(stall), .branch_en(branch_en), .branch_val(branch_val), .ex_ready(ex_ready),
    .zero_flag(zero_flag), .dec_valid(dec_valid), .dec_op(dec_op), .dec_imm(dec_imm),
    .dec_pc(dec_pc), .illegal(illegal), .halted(halted), .perf_taken(perf_taken),
    .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // Fetch model: redirect is combinational, stall holds the PC, memory is 2 cycles.
  assign fetch_addr = branch_en ? branch_val : pc_q;
  assign ins        = mem[a2[9:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      a1   <= '0;
      a2   <= '0;
    end else begin
      if (core_en && !stall) pc_q <= fetch_addr + 16'd1;
      a1 <= fetch_addr;
      a2 <= a1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  // Architectural walk from PC 0 until HALT; pushes the expected issue stream.
  task automatic arch_walk(input logic zf);
    logic [15:0] pc;
    logic [15:0] w;
    exp_t        e;
    bit          done;
    pc   = '0;
    done = 0;
    for (int n = 0; n < 64 && !done; n++) begin
      w        = mem[pc[9:0]];
      e.pc     = pc;
      e.op     = w[15:12];
      e.imm    = {{4{w[11]}}, w[11:0]};
      e.taken  = (e.op == 4'h7) || (e.op == 4'h5 && zf) || (e.op == 4'h6 && !zf);
      e.target = (e.op == 4'h7) ? {4'h0, w[11:0]} : pc + e.imm;
      exp_q.push_back(e);
      if (e.op == 4'hF) done = 1;
      else pc = e.taken ? e.target : pc + 16'd1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    check("illegal_pulse", illegal, prev_ill);
    prev_ill = 1'b0;
    if (dec_valid && !ex_ready) check("stall_hold", stall, 1);
    if (dec_valid && ex_ready) begin
      issue_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("extra_issue", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("dec_pc", dec_pc, e.pc);
        check("dec_op", dec_op, e.op);
        check("dec_imm", dec_imm, e.imm);
        check("branch_en", branch_en, e.taken);
        if (e.taken) begin
          check("branch_val", branch_val, e.target);
          check("branch_stall", stall, 0);
        end
        if (chk_stall0) check("stall_run", stall, 0);
        prev_ill = (e.op >= 4'h8) && (e.op != 4'hF);
      end
    end else begin
      check("branch_idle", branch_en, 0);
    end
  endtask

  // Per-cycle ex_ready driver followed by output sampling.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (hold_left > 0 && dec_valid && dec_pc == hold_pc) begin
      ex_ready = 1'b0;
      hold_left--;
    end else begin
      ex_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    if (mon_en) monitor();
  end

  task automatic start_prog(input logic zf, input int hold_at, input int hold_n, input bit rnd);
    mon_en = 0;
    rst_n  = 1'b0;
    core_en = 1'b1;
    exp_q.delete();
    issue_cyc.delete();
    prev_ill  = 1'b0;
    zero_flag = zf;
    rnd_ready = rnd;
    hold_pc   = 16'(hold_at);
    hold_left = hold_n;
    arch_walk(zf);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
  endtask

  task automatic finish_prog();
    int budget = 0;
    while ((exp_q.size() != 0 || !halted) && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    check("drain_left", 32'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
    #2;
    check("halted", halted, 1);
    check("halt_stall", stall, 1);
    check("halt_valid", dec_valid, 0);
  endtask

  initial begin
    int budget;

    // Reset values.
    core_en = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("rst_valid", dec_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_stall", stall, 0);
    check("rst_branch", branch_en, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc", dec_pc, 0);
    check("rst_perf_taken", perf_taken, 0);

    // Straight line with full throughput.
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h2FFF; mem[2] = 16'h4000; mem[3] = 16'hF000;
    chk_stall0 = 1;
    start_prog(1'b0, 0, 0, 0);
    finish_prog();
    chk_stall0 = 0;
    check("line_issues", 32'(issue_cyc.size()), 4);
    for (int i = 1; i < issue_cyc.size(); i++)
      check("line_consec", 32'(issue_cyc[i] - issue_cyc[i-1]), 1);

    // ex_ready low 3 cycles mid-stream: skid absorbs in-flight words.
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8] = 16'hF000;
    start_prog(1'b0, 3, 3, 0);
    finish_prog();

    // JZ at PC 8: taken and not taken.
    clear_mem();
    mem[0] = 16'h7005; mem[4] = 16'hF000;
    mem[5] = 16'h1005; mem[6] = 16'h1006; mem[7] = 16'h1007; mem[8] = 16'h5FFC;
    mem[9] = 16'h1009; mem[10] = 16'h100A; mem[11] = 16'hF000;
    start_prog(1'b1, 0, 0, 0);
    finish_prog();
    start_prog(1'b0, 0, 0, 0);
    finish_prog();

    // JMP issued with two skidded words behind it.
    clear_mem();
    mem[0] = 16'h1000; mem[1] = 16'h1001; mem[2] = 16'h1002; mem[3] = 16'h7123;
    mem[4] = 16'h1004; mem[5] = 16'h1005; mem[6] = 16'hF000;
    mem[16'h123] = 16'h1123; mem[16'h124] = 16'hF000;
    start_prog(1'b0, 3, 3, 0);
    finish_prog();

    // Illegal opcode then HALT; nothing past HALT may issue.
    clear_mem();
    mem[0] = 16'h1000; mem[1] = 16'h9000; mem[2] = 16'h2000; mem[3] = 16'hF000;
    mem[4] = 16'h1004; mem[5] = 16'h1005;
    start_prog(1'b0, 0, 0, 0);
    finish_prog();
    repeat (5) @(negedge clk);
    #2;
    check("halt_sticky_stall", stall, 1);
    check("halt_sticky", halted, 1);

    // Three taken branches under random back-pressure.
    clear_mem();
    mem[0] = 16'h7002; mem[1] = 16'h9000; mem[2] = 16'h6001; mem[3] = 16'h7006;
    mem[4] = 16'h9000; mem[5] = 16'h9000; mem[6] = 16'hF000;
    start_prog(1'b0, 0, 0, 1);
    finish_prog();
`ifdef DECODE_PERF_EN
    check("perf_taken", perf_taken, 3);
`else
    check("perf_taken_off", perf_taken, 0);
    check("perf_stall_off", perf_stall, 0);
`endif
    rnd_ready = 0;

    // Asynchronous reset while words are skidded.
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8] = 16'hF000;
    start_prog(1'b0, 2, 20, 0);
    budget = 0;
    while (hold_left > 16 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("skid_reached", 32'(hold_left), 16);
    #3;
    check("skid_stall", stall, 1);
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check("arst_valid", dec_valid, 0);
    check("arst_stall", stall, 0);
    check("arst_pc", dec_pc, 0);
    check("arst_op", dec_op, 0);
    check("arst_imm", dec_imm, 0);
    check("arst_branch", branch_en, 0);
    check("arst_bval", branch_val, 0);
    check("arst_halted", halted, 0);
    check("arst_perf", perf_taken, 0);
    hold_left = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
